gpp_rx_buffer: RTL and testbench

Receive-side buffer between the photonic network interface and the GPP. Accepts 16-bit words with an end-of-packet marker from the network, stores them in a first-word-fall-through FIFO, and presents them to the GPP on `RAM_rx_data_out` / `data_rx_flag`. Tracks how many complete packets are held and signals the GPP through `gpp_trf_cp`. The GPP pops words with `gpp_rtr_dp`.

---
 rtl/gpp_rx_buffer.sv | 143 ++++++++++++++
 tb/tb_gpp_rx_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpp_rx_buffer.sv
// gpp_rx_buffer
// Receive-side buffer between the photonic network interface and the GPP.
// Network words and their end-of-packet bit go into a first-word-fall-through
// FIFO. The head word is presented to the GPP, and the buffer counts how many
// complete packets it holds.
// Optional feature macro: GPP_RX_DROP_COUNT_EN. When it is defined, the buffer
// keeps a saturating drop counter and a sticky overflow flag. When it is not
// defined, both outputs are tied to zero.

module gpp_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         net_data,
    input  logic                     net_last,
    input  logic                     net_valid,
    output logic                     net_ready,
    input  logic                     enable_rtr,
    input  logic                     gpp_rtr_dp,
    output logic [WIDTH-1:0]         RAM_rx_data_out,
    output logic                     rx_last,
    output logic                     data_rx_flag,
    output logic                     gpp_trf_cp,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [7:0]               drop_count,
    output logic                     overflow,
    input  logic                     drop_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_rxCount;
    logic [CW-1:0]   r_pktCount;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_headLast;

    // The push and drop decisions use the pre-edge full flag, so a pop in
    // the same cycle never frees space for the incoming word.
    assign w_full     = (r_rxCount == CW'(DEPTH));
    assign w_empty    = (r_rxCount == '0);
    assign w_push     = net_valid && enable_rtr && !w_full;
    assign w_drop     = net_valid && (!enable_rtr || w_full);
    assign w_pop      = gpp_rtr_dp && !w_empty;
    assign w_headLast = r_mem[r_rdPtr][WIDTH];

    assign net_ready       = enable_rtr && !w_full;
    assign RAM_rx_data_out = r_mem[r_rdPtr][WIDTH-1:0];
    assign rx_last         = w_headLast;
    assign data_rx_flag    = !w_empty;
    assign gpp_trf_cp      = (r_pktCount != '0);
    assign rx_count        = r_rxCount;

    // Store each accepted word together with its last flag. The array is
    // intentionally left unreset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {net_last, net_data};
        end
    end

    // Advance the write and read pointers. Both wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Track the word occupancy. A simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxCount <= '0;
        end else if (w_push && !w_pop) begin
            r_rxCount <= r_rxCount + 1'b1;
        end else if (w_pop && !w_push) begin
            r_rxCount <= r_rxCount - 1'b1;
        end
    end

    // Count complete packets. A packet is added when its last word is pushed
    // and removed when that last word is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pktCount <= '0;
        end else begin
            case ({w_push && net_last, w_pop && w_headLast})
                2'b10:   r_pktCount <= r_pktCount + 1'b1;
                2'b01:   r_pktCount <= r_pktCount - 1'b1;
                default: r_pktCount <= r_pktCount;
            endcase
        end
    end

`ifdef GPP_RX_DROP_COUNT_EN
    logic [7:0] r_dropCount;
    logic       r_overflow;

    // Count dropped words, saturating at 255. A drop that coincides with a
    // clear counts as the first drop after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dropCount <= '0;
            r_overflow  <= 1'b0;
        end else if (drop_clear) begin
            r_dropCount <= w_drop ? 8'd1 : 8'd0;
            r_overflow  <= w_drop;
        end else if (w_drop) begin
            if (r_dropCount != 8'hFF) begin
                r_dropCount <= r_dropCount + 8'd1;
            end
            r_overflow <= 1'b1;
        end
    end

    assign drop_count = r_dropCount;
    assign overflow   = r_overflow;
`else
    logic w_unusedDrop;

    assign w_unusedDrop = drop_clear ^ w_drop;
    assign drop_count   = 8'd0;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_gpp_rx_buffer.sv
// tb_gpp_rx_buffer
// This is a directed testbench for gpp_rx_buffer with DEPTH=8 and WIDTH=16.
// The drop statistics depend on GPP_RX_DROP_COUNT_EN. The expected values
// follow the same macro.

module tb_gpp_rx_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] net_data;
    logic        net_last;
    logic        net_valid;
    logic        net_ready;
    logic        enable_rtr;
    logic        gpp_rtr_dp;
    logic [15:0] RAM_rx_data_out;
    logic        rx_last;
    logic        data_rx_flag;
    logic        gpp_trf_cp;
    logic [3:0]  rx_count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        drop_clear;

    int compared   = 0;
    int mismatched = 0;

`ifdef GPP_RX_DROP_COUNT_EN
    localparam bit DropEn = 1'b1;
`else
    localparam bit DropEn = 1'b0;
`endif

    gpp_rx_buffer #(.DEPTH(8), .WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .net_data        (net_data),
        .net_last        (net_last),
        .net_valid       (net_valid),
        .net_ready       (net_ready),
        .enable_rtr      (enable_rtr),
        .gpp_rtr_dp      (gpp_rtr_dp),
        .RAM_rx_data_out (RAM_rx_data_out),
        .rx_last         (rx_last),
        .data_rx_flag    (data_rx_flag),
        .gpp_trf_cp      (gpp_trf_cp),
        .rx_count        (rx_count),
        .drop_count      (drop_count),
        .overflow        (overflow),
        .drop_clear      (drop_clear)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of network and pop inputs, then release them 1 ns after the edge
    task automatic applyStimulus(input logic valid, input logic last,
                                 input logic [15:0] data, input logic pop);
        net_valid  = valid;
        net_last   = last;
        net_data   = data;
        gpp_rtr_dp = pop;
        @(posedge clk);
        #1;
        net_valid  = 1'b0;
        net_last   = 1'b0;
        gpp_rtr_dp = 1'b0;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed test sequence
    initial begin
        rst        = 1'b1;
        net_data   = '0;
        net_last   = 1'b0;
        net_valid  = 1'b0;
        enable_rtr = 1'b1;
        gpp_rtr_dp = 1'b0;
        drop_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_flag",     data_rx_flag, 0);
        checkOutput("rst_trf",      gpp_trf_cp,   0);
        checkOutput("rst_count",    rx_count,     0);
        checkOutput("rst_drop",     drop_count,   0);
        checkOutput("rst_ovf",      overflow,     0);
        checkOutput("rst_ready",    net_ready,    1);
        rst = 1'b0;

        // Single packet
        applyStimulus(1, 0, 16'h1111, 0);
        checkOutput("p1_flag",      data_rx_flag,    1);
        checkOutput("p1_head",      RAM_rx_data_out, 16'h1111);
        checkOutput("p1_trf_open",  gpp_trf_cp,      0);
        applyStimulus(1, 0, 16'h2222, 0);
        applyStimulus(1, 1, 16'h3333, 0);
        checkOutput("p1_trf",       gpp_trf_cp,      1);
        checkOutput("p1_count",     rx_count,        3);
        checkOutput("p1_d0",        RAM_rx_data_out, 16'h1111);
        checkOutput("p1_l0",        rx_last,         0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("p1_d1",        RAM_rx_data_out, 16'h2222);
        checkOutput("p1_l1",        rx_last,         0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("p1_d2",        RAM_rx_data_out, 16'h3333);
        checkOutput("p1_l2",        rx_last,         1);
        checkOutput("p1_trf_hold",  gpp_trf_cp,      1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("p1_empty",     data_rx_flag,    0);
        checkOutput("p1_trf_done",  gpp_trf_cp,      0);

        // Fill and drop: ten pushes into eight entries
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1, 0, 16'(i), 0);
            if (i == 8) begin
                checkOutput("fill_ready8", net_ready, 0);
                checkOutput("fill_count8", rx_count,  8);
            end
        end
        checkOutput("fill_count",   rx_count,   8);
        checkOutput("fill_drops",   drop_count, DropEn ? 2 : 0);
        checkOutput("fill_ovf",     overflow,   DropEn ? 1 : 0);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("fill_pop", RAM_rx_data_out, 16'(i));
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("fill_empty",   data_rx_flag, 0);
        drop_clear = 1'b1;
        applyStimulus(0, 0, 0, 0);
        drop_clear = 1'b0;
        checkOutput("clr_drops",    drop_count, 0);
        checkOutput("clr_ovf",      overflow,   0);

        // A drop in the same cycle as a clear leaves one counted drop
        enable_rtr = 1'b0;
        drop_clear = 1'b1;
        applyStimulus(1, 0, 16'h0055, 0);
        drop_clear = 1'b0;
        enable_rtr = 1'b1;
        checkOutput("clrdrop_cnt",  drop_count,   DropEn ? 1 : 0);
        checkOutput("clrdrop_ovf",  overflow,     DropEn ? 1 : 0);
        checkOutput("clrdrop_empty", data_rx_flag, 0);
        drop_clear = 1'b1;
        applyStimulus(0, 0, 0, 0);
        drop_clear = 1'b0;
        checkOutput("clr2_drops",   drop_count, 0);

        // Simultaneous push and pop with four words held
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 16'hA0 + 16'(i), 0);
        end
        applyStimulus(1, 0, 16'h00A4, 1);
        checkOutput("pp4_count",    rx_count, 4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("pp4_order", RAM_rx_data_out, 16'hA0 + 16'(i));
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("pp4_empty",    data_rx_flag, 0);

        // Push and pop when full: the pushed word is dropped
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 16'hB0 + 16'(i), 0);
        end
        applyStimulus(1, 0, 16'h00B8, 1);
        checkOutput("pp8_count",    rx_count,   7);
        checkOutput("pp8_drop",     drop_count, DropEn ? 1 : 0);
        for (int i = 1; i <= 7; i++) begin
            checkOutput("pp8_order", RAM_rx_data_out, 16'hB0 + 16'(i));
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("pp8_empty",    data_rx_flag, 0);

        // Wrap-around: push and pop together for 20 cycles
        applyStimulus(1, 0, 16'h0100, 0);
        for (int i = 1; i <= 20; i++) begin
            checkOutput("wrap_head", RAM_rx_data_out, 16'h0100 + 16'(i - 1));
            applyStimulus(1, 0, 16'h0100 + 16'(i), 1);
        end
        checkOutput("wrap_count",   rx_count,        1);
        checkOutput("wrap_last",    RAM_rx_data_out, 16'h0114);
        applyStimulus(0, 0, 0, 1);
        checkOutput("wrap_empty",   data_rx_flag,    0);

        // Receive disabled with three words held: new words drop, and draining continues
        applyStimulus(1, 0, 16'h00C1, 0);
        applyStimulus(1, 0, 16'h00C2, 0);
        applyStimulus(1, 1, 16'h00C3, 0);
        enable_rtr = 1'b0;
        #1;
        checkOutput("dis_ready",    net_ready, 0);
        applyStimulus(1, 0, 16'h00C4, 0);
        applyStimulus(1, 1, 16'h00C5, 0);
        checkOutput("dis_count",    rx_count,   3);
        checkOutput("dis_drops",    drop_count, DropEn ? 3 : 0);
        for (int i = 1; i <= 3; i++) begin
            checkOutput("dis_pop", RAM_rx_data_out, 16'hC0 + 16'(i));
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("dis_empty",    data_rx_flag, 0);
        checkOutput("dis_trf",      gpp_trf_cp,   0);
        enable_rtr = 1'b1;

        // Reset with a complete packet and an open packet held
        applyStimulus(1, 1, 16'h00E1, 0);
        applyStimulus(1, 0, 16'h00D1, 0);
        applyStimulus(1, 0, 16'h00D2, 0);
        checkOutput("mid_trf",      gpp_trf_cp, 1);
        checkOutput("mid_count",    rx_count,   3);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        rst = 1'b0;
        checkOutput("mrst_flag",    data_rx_flag, 0);
        checkOutput("mrst_count",   rx_count,     0);
        checkOutput("mrst_trf",     gpp_trf_cp,   0);
        checkOutput("mrst_drop",    drop_count,   0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("mrst_pop_flag",  data_rx_flag, 0);
        checkOutput("mrst_pop_count", rx_count,     0);
        applyStimulus(1, 0, 16'h00F1, 0);
        checkOutput("mrst_head",    RAM_rx_data_out, 16'h00F1);
        checkOutput("mrst_count1",  rx_count,        1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
